// File: rtl/phase_driver_pkg.sv
// Shared definitions for the phase driver and the phase state machine it
// steers: phase encodings, driver FSM state codes and the next-phase rule.
// Both sides import this package so they always agree on the values.
package phase_driver_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_INIT = 3'd0;
  localparam phase_t PH_A    = 3'd1;
  localparam phase_t PH_B    = 3'd2;
  localparam phase_t PH_C    = 3'd3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADV       = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_CHECK     = 3'd5;
  localparam logic [2:0] ST_ERR       = 3'd6;

  typedef struct packed {
    logic   valid;
    phase_t phase;
  } next_phase_t;

  // INIT->A->B->C->A; any other code has no successor.
  function automatic next_phase_t next_phase(input phase_t cur);
    next_phase_t r;
    r = '{valid: 1'b1, phase: PH_INIT};
    case (cur)
      PH_INIT: r.phase = PH_A;
      PH_A:    r.phase = PH_B;
      PH_B:    r.phase = PH_C;
      PH_C:    r.phase = PH_A;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phase_driver_if.sv
// Bundle of the job-control and phase-handshake signals of phase_driver.
//   start, cfg_phases     : job request and phase count
//   current_state         : phase echo from the phase state machine
//   eng_done              : engine phase-complete pulse
//   state_rst, eng_start  : advance / engine-start pulses
//   busy, job_done, err   : status
// master = job/environment side, slave = phase_driver.
interface phase_driver_if #(
  parameter int CNT_W = 8
);
  import phase_driver_pkg::*;

  logic             start;
  logic [CNT_W-1:0] cfg_phases;
  phase_t           current_state;
  logic             eng_done;
  logic             state_rst;
  logic             eng_start;
  logic             busy;
  logic             job_done;
  logic             err;

  modport master (
    output start, cfg_phases, current_state, eng_done,
    input  state_rst, eng_start, busy, job_done, err
  );

  modport slave (
    input  start, cfg_phases, current_state, eng_done,
    output state_rst, eng_start, busy, job_done, err
  );

endinterface

// File: rtl/phase_driver_ack_timer.sv
// Acknowledge watchdog for phase_driver.
//   clk, rstn : clock, synchronous active-low reset
//   load      : restart the window (driver in ADV)
//   count     : window is running (driver in WAIT_ACK)
//   expired   : high in the last cycle of an ACK_TIMEOUT-cycle window
module phase_driver_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] remain;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      remain <= '0;
    end else if (load) begin
      remain <= LOAD_VAL;
    end else if (count && remain != '0) begin
      remain <= remain - 1'b1;
    end
  end

  assign expired = count && (remain == '0);

endmodule

// File: rtl/phase_driver.sv
// Phase driver: runs a job of cfg_phases phases. Each phase advances the
// external phase state machine (state_rst), waits for its state echo, starts
// the engine (eng_start) and waits for eng_done. A bad or missing echo parks
// the driver in ERR with a sticky err until reset or a new start.
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : phase_driver_if slave modport (job control, handshake, status)
module phase_driver
  import phase_driver_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rstn,
  phase_driver_if.slave  bus
);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] phases, phases_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  phase_t           expect_q, expect_nxt;
  phase_t           prev_q, prev_nxt;
  next_phase_t      adv;
  logic             done_nxt;
  logic             tmr_expired;

  logic state_rst_q, eng_start_q, job_done_q, busy_q, err_q;

  phase_driver_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rstn   (rstn),
    .load   (state == ST_ADV),
    .count  (state == ST_WAIT_ACK),
    .expired(tmr_expired)
  );

  always_comb begin
    state_nxt  = state;
    phases_nxt = phases;
    count_nxt  = count;
    expect_nxt = expect_q;
    prev_nxt   = prev_q;
    done_nxt   = 1'b0;
    adv        = next_phase(bus.current_state);

    case (state)
      // ERR accepts a new job exactly like IDLE; leaving ERR clears err.
      ST_IDLE, ST_ERR: begin
        if (bus.start) begin
          if (bus.cfg_phases != '0) begin
            phases_nxt = bus.cfg_phases;
            count_nxt  = '0;
            state_nxt  = ST_ADV;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_ADV: begin
        // current_state is still the pre-advance value here.
        prev_nxt   = bus.current_state;
        expect_nxt = adv.phase;
        state_nxt  = adv.valid ? ST_WAIT_ACK : ST_ERR;
      end
      ST_WAIT_ACK: begin
        // A matching echo wins over a timeout expiring in the same cycle.
        if (bus.current_state == expect_q) begin
          state_nxt = ST_RUN;
        end else if (bus.current_state != prev_q) begin
          state_nxt = ST_ERR;
        end else if (tmr_expired) begin
          state_nxt = ST_ERR;
        end
      end
      ST_RUN: begin
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.eng_done) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        count_nxt = count + 1'b1;
        if (count_nxt == phases) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ADV;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are flops loaded from the next-state decode so they line up
  // with the state they belong to without any input-to-output path.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      phases      <= '0;
      count       <= '0;
      expect_q    <= PH_INIT;
      prev_q      <= PH_INIT;
      state_rst_q <= 1'b0;
      eng_start_q <= 1'b0;
      job_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      phases      <= phases_nxt;
      count       <= count_nxt;
      expect_q    <= expect_nxt;
      prev_q      <= prev_nxt;
      state_rst_q <= (state_nxt == ST_ADV);
      eng_start_q <= (state_nxt == ST_RUN);
      job_done_q  <= done_nxt;
      busy_q      <= (state_nxt != ST_IDLE);
      err_q       <= (state_nxt == ST_ERR);
    end
  end

  assign bus.state_rst = state_rst_q;
  assign bus.eng_start = eng_start_q;
  assign bus.job_done  = job_done_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_phase_driver.sv
// Self-checking bench for phase_driver. The bench plays the phase state
// machine and the engine with per-phase delays, predicts the complete output
// waveform of each job from its timing rules and compares every cycle.
module tb_phase_driver;

  localparam int CNT_W = 8;
  localparam int T     = 16;
  localparam int NCYC  = 30000;
  localparam int MAXP  = 256;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  phase_driver_if #(.CNT_W(CNT_W)) bus ();

  phase_driver #(
    .CNT_W      (CNT_W),
    .ACK_TIMEOUT(T)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // expected {state_rst, eng_start, job_done, busy, err} per cycle
  logic [4:0] exp_v [NCYC];
  bit chk_en = 1'b0;

  int ack_d [MAXP];
  int eng_d [MAXP];

  int         sm_mode = 0;   // 0 normal, 1 never acks, 2 jumps A->C
  int         sm_idx  = 0;
  int         en_idx  = 0;
  bit         sm_pend = 1'b0;
  int         sm_cnt  = 0;
  logic [2:0] sm_val  = 3'd0;
  logic [2:0] cur     = 3'd0;
  bit         en_pend = 1'b0;
  int         en_cnt  = 0;
  bit         spur_req = 1'b0;
  logic       eng_done_drv = 1'b0;

  int n_rst = 0, n_es = 0, n_jd = 0;
  int first_err = -1;
  int last_jd = -1;
  int seq_q [$];

  assign bus.current_state = cur;
  assign bus.eng_done      = eng_done_drv;

  function automatic int nxt(input int x);
    return x % 3 + 1;
  endfunction

  function automatic int seq_code();
    int v = 0;
    foreach (seq_q[i]) v = v * 10 + seq_q[i];
    return v;
  endfunction

  function automatic void fill_idle(input int from, input bit err_v);
    for (int c = from; c < NCYC; c++) exp_v[c] = {4'b0000, err_v};
  endfunction

  function automatic void set_busy(input int a, input int b);
    for (int c = a; c <= b && c < NCYC; c++) exp_v[c][1] = 1'b1;
  endfunction

  function automatic void set_err_from(input int a);
    for (int c = a; c < NCYC; c++) exp_v[c][0] = 1'b1;
  endfunction

  function automatic void pulse(input int c, input int bitpos);
    if (c < NCYC) exp_v[c][bitpos] = 1'b1;
  endfunction

  task automatic check_int(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic set_delays(input int alo, input int ahi, input int elo, input int ehi);
    for (int i = 0; i < MAXP; i++) begin
      ack_d[i] = $urandom_range(ahi, alo);
      eng_d[i] = $urandom_range(ehi, elo);
    end
  endtask

  // Per-cycle comparison and event monitors; outputs sampled mid-cycle.
  always @(negedge clk) begin
    logic [4:0] got;
    got = {bus.state_rst, bus.eng_start, bus.job_done, bus.busy, bus.err};
    if (chk_en && cyc < NCYC) begin
      checks++;
      if (got !== exp_v[cyc]) begin
        errors++;
        $display("FAIL outputs cycle=%0d got=%b expected=%b (state_rst,eng_start,job_done,busy,err)",
                 cyc, got, exp_v[cyc]);
      end
    end
    if (bus.state_rst === 1'b1) begin
      n_rst++;
      if (sm_mode != 1) begin
        sm_pend = 1'b1;
        sm_cnt  = ack_d[sm_idx % MAXP];
        sm_val  = (sm_mode == 2 && cur == 3'd1) ? 3'd3 : 3'(nxt(int'(cur)));
      end
      sm_idx++;
    end
    if (bus.eng_start === 1'b1) begin
      n_es++;
      en_pend = 1'b1;
      en_cnt  = eng_d[en_idx % MAXP];
      en_idx++;
    end
    if (bus.job_done === 1'b1) begin
      n_jd++;
      last_jd = cyc;
    end
    if (bus.err === 1'b1 && first_err < 0) first_err = cyc;
  end

  // Phase state machine and engine responses.
  always @(posedge clk) begin
    #1;
    eng_done_drv = 1'b0;
    if (sm_pend) begin
      if (sm_cnt == 0) begin
        cur = sm_val;
        seq_q.push_back(int'(sm_val));
        sm_pend = 1'b0;
      end else begin
        sm_cnt--;
      end
    end
    if (en_pend) begin
      if (en_cnt <= 1) begin
        eng_done_drv = 1'b1;
        en_pend = 1'b0;
      end else begin
        en_cnt--;
      end
    end else if (spur_req) begin
      eng_done_drv = 1'b1;
      spur_req = 1'b0;
    end
  end

  // Drives start in cycle n and predicts the whole job from n+1 on.
  task automatic launch(input int cfg, input int mode, output int n, output int end_c);
    int r, s, c;
    @(posedge clk); #1;
    n = cyc;
    sm_mode = mode;
    sm_idx = 0; en_idx = 0; seq_q.delete();
    n_rst = 0; n_es = 0; n_jd = 0; first_err = -1; last_jd = -1;
    bus.start = 1'b1;
    bus.cfg_phases = CNT_W'(cfg);
    fill_idle(n + 1, 1'b0);
    c = int'(cur);
    end_c = -1;
    if (cfg == 0) begin
      pulse(n + 1, 2);
      end_c = n + 3;
    end else begin
      r = n + 1;
      for (int p = 0; p < cfg; p++) begin
        pulse(r, 4);
        if (mode == 1) begin
          set_busy(n + 1, NCYC - 1);
          set_err_from(r + 1 + T);
          end_c = r + T + 3;
          break;
        end
        if (mode == 2 && c == 1) begin
          set_busy(n + 1, NCYC - 1);
          set_err_from(r + 2 + ack_d[p]);
          end_c = r + ack_d[p] + 4;
          break;
        end
        s = r + 2 + ack_d[p];
        pulse(s, 3);
        r = s + eng_d[p] + 2;
        c = nxt(c);
      end
      if (end_c < 0) begin
        pulse(r, 2);
        set_busy(n + 1, r - 1);
        end_c = r + 2;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cfg_phases = CNT_W'($urandom_range(255, 0));
  endtask

  task automatic poke(input int cfg);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.cfg_phases = CNT_W'(cfg);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic settle(input int end_c);
    while (cyc < end_c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : main
    int n, e, q, budget, cfg;
    for (int c = 0; c < NCYC; c++) exp_v[c] = '0;
    bus.start = 1'b0;
    bus.cfg_phases = '0;
    for (int i = 0; i < MAXP; i++) begin ack_d[i] = 0; eng_d[i] = 1; end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check_int("reset_outputs",
              int'({bus.state_rst, bus.eng_start, bus.job_done, bus.busy, bus.err}), 0);
    rstn = 1'b1;

    // three phases from INIT, ack after one cycle, engine takes 5 cycles
    cur = 3'd0;
    set_delays(0, 0, 5, 5);
    launch(3, 0, n, e);
    settle(e);
    check_int("seq_3phase", seq_code(), 123);
    check_int("eng_start_count_3", n_es, 3);
    check_int("job_done_count_3", n_jd, 1);
    check_int("job_done_latency_3", last_jd - n, 28);
    check_int("err_after_3", int'(bus.err), 0);

    // five phases starting from C
    cur = 3'd3;
    set_delays(0, 0, 1, 6);
    launch(5, 0, n, e);
    settle(e);
    check_int("seq_5phase", seq_code(), 12312);
    check_int("eng_start_count_5", n_es, 5);
    check_int("job_done_count_5", n_jd, 1);

    // no acknowledge at all
    cur = 3'd1;
    set_delays(0, 0, 1, 3);
    launch(2, 1, n, e);
    settle(e);
    check_int("timeout_err_latency", first_err - n, 18);
    check_int("timeout_no_eng_start", n_es, 0);
    check_int("timeout_err_sticky", int'(bus.err), 1);
    check_int("timeout_busy", int'(bus.busy), 1);

    // recovery from ERR with a new start
    set_delays(0, 2, 1, 4);
    launch(2, 0, n, e);
    settle(e);
    check_int("recover_seq", seq_code(), 23);
    check_int("recover_err", int'(bus.err), 0);
    check_int("recover_job_done", n_jd, 1);

    // state machine jumps A->C on advance
    cur = 3'd1;
    set_delays(0, 0, 1, 3);
    ack_d[0] = 1;
    launch(2, 2, n, e);
    settle(e);
    check_int("jump_err_latency", first_err - n, 4);
    check_int("jump_no_eng_start", n_es, 0);
    set_delays(0, 0, 2, 2);
    launch(1, 0, n, e);
    settle(e);
    check_int("after_jump_seq", seq_code(), 1);
    check_int("after_jump_job_done", n_jd, 1);
    check_int("after_jump_err", int'(bus.err), 0);

    // start while busy is ignored; zero-phase start completes at once
    cur = 3'd0;
    set_delays(0, 1, 2, 4);
    launch(2, 0, n, e);
    poke(7);
    settle(e);
    check_int("busy_start_advances", n_rst, 2);
    check_int("busy_start_job_done", n_jd, 1);
    launch(0, 0, n, e);
    settle(e);
    check_int("zero_cfg_no_state_rst", n_rst, 0);
    check_int("zero_cfg_job_done", n_jd, 1);
    check_int("zero_cfg_latency", last_jd - n, 1);

    // reset in WAIT_DONE of phase 2, engine completion arrives afterwards
    cur = 3'd0;
    set_delays(0, 0, 6, 6);
    launch(3, 0, n, e);
    budget = 0;
    while (n_es < 2 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check_int("reset_reached_phase2", n_es, 2);
    @(posedge clk); #1;
    rstn = 1'b0;
    q = cyc;
    fill_idle(q + 1, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check_int("reset_no_job_done", n_jd, 0);
    check_int("reset_busy", int'(bus.busy), 0);

    // acknowledge in the last cycle of the window
    cur = 3'd2;
    set_delays(T - 1, T - 1, 1, 3);
    launch(2, 0, n, e);
    settle(e);
    check_int("late_ack_job_done", n_jd, 1);
    check_int("late_ack_eng_start", n_es, 2);
    check_int("late_ack_err", int'(bus.err), 0);

    // largest phase count
    cur = 3'd0;
    set_delays(0, 0, 1, 1);
    launch(255, 0, n, e);
    settle(e);
    check_int("max_cfg_eng_start", n_es, 255);
    check_int("max_cfg_job_done", n_jd, 1);

    // randomized jobs
    for (int j = 0; j < 12; j++) begin
      cur = 3'($urandom_range(3, 0));
      cfg = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(6, 1));
      set_delays(0, 4, 1, 7);
      if ($urandom_range(3, 0) == 0) ack_d[$urandom_range(5, 0)] = T - 1;
      launch(cfg, 0, n, e);
      if (cfg != 0 && $urandom_range(1, 0) == 1) poke(int'($urandom_range(255, 0)));
      settle(e);
      check_int("random_job_done", n_jd, 1);
      check_int("random_eng_start", n_es, cfg);
      if ($urandom_range(1, 0) == 1) spur_req = 1'b1;
      repeat ($urandom_range(4, 2)) begin @(posedge clk); #1; end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
